// File: rtl/ram_w32r16_fifo_ctrl.sv
// rtl/ram_w32r16_fifo_ctrl.sv - FIFO sequencer for a 512x32-write / 1024x16-read RAM
// Pushes whole 32-bit words; pops 16-bit halfwords, low half first.
module ram_w32r16_fifo_ctrl #(
  parameter int AFULL_THRESH  = 960,
  parameter int AEMPTY_THRESH = 64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Flush,
  input  logic        Push,
  input  logic [31:0] Push_Data,
  input  logic        Pop,
  output logic [15:0] Pop_Data,
  output logic        Pop_Valid,
  output logic        Full,
  output logic        Empty,
  output logic        Almost_Full,
  output logic        Almost_Empty,
  output logic [10:0] Count,
  output logic        Overflow,
  output logic        Underflow,
  output logic [8:0]  Ram_WA,
  output logic [31:0] Ram_WD,
  output logic [3:0]  Ram_WEN,
  output logic        Ram_WClk_En,
  output logic [9:0]  Ram_RA,
  output logic        Ram_RClk_En,
  input  logic [15:0] Ram_RD
);

  localparam logic [10:0] AFULL_LVL  = 11'(AFULL_THRESH);
  localparam logic [10:0] AEMPTY_LVL = 11'(AEMPTY_THRESH);
  localparam logic [10:0] FULL_LVL   = 11'd1022;

  logic [8:0]  wptr;
  logic [9:0]  rptr;
  logic [10:0] count;
  logic [10:0] count_nxt;
  logic        pop_valid_q;
  logic        overflow_q;
  logic        underflow_q;
  logic        full;
  logic        empty;
  logic        push_ok;
  logic        pop_ok;

  // Full leaves no room for a whole 32-bit word (two halfwords)
  assign full  = (count > FULL_LVL);
  assign empty = (count == 11'd0);

  // Flush wins over any request in the same cycle, so it also gates the RAM enables
  assign push_ok = Push & ~full & ~Flush;
  assign pop_ok  = Pop & ~empty & ~Flush;

  always_comb begin
    count_nxt = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 11'd2;
      2'b01:   count_nxt = count - 11'd1;
      2'b11:   count_nxt = count + 11'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (Flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 9'd1;
      if (pop_ok)  rptr <= rptr + 10'd1;
      count       <= count_nxt;
      pop_valid_q <= pop_ok;
      overflow_q  <= overflow_q | (Push & full);
      underflow_q <= underflow_q | (Pop & empty);
    end
  end

  // Halfword address {word, sel}: sel=0 selects bits [15:0] of the stored word
  assign Ram_WA      = wptr;
  assign Ram_WD      = Push_Data;
  assign Ram_WEN     = push_ok ? 4'hF : 4'h0;
  assign Ram_WClk_En = push_ok;
  assign Ram_RA      = rptr;
  assign Ram_RClk_En = pop_ok;

  assign Pop_Data     = Ram_RD;
  assign Pop_Valid    = pop_valid_q;
  assign Count        = count;
  assign Full         = full;
  assign Empty        = empty;
  assign Almost_Full  = (count >= AFULL_LVL);
  assign Almost_Empty = (count <= AEMPTY_LVL);
  assign Overflow     = overflow_q;
  assign Underflow    = underflow_q;

endmodule

// File: doc/ram_w32r16_fifo_ctrl.md
Name: ram_w32r16_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences a concatenated 16K RAM block configured as 512x32 write / 1024x16 read. It accepts 32-bit push words, writes them as full-width RAM words, and returns them as 16-bit pops: low half first, then high half. It owns the RAM address pointers, write enables, clock enables, occupancy tracking and error flags, and sits between a 32-bit producer and a 16-bit consumer.

Parameters:
AFULL_THRESH, 960, halfword occupancy at or above which Almost_Full asserts (range 2..1022)
AEMPTY_THRESH, 64, halfword occupancy at or below which Almost_Empty asserts (range 0..1022)

Ports:
Clk  input  1  single clock; also drives the RAM WClk and RClk
Rst_n  input  1  asynchronous active-low reset
Flush  input  1  synchronous clear of pointers, count and flags
Push  input  1  push request, one 32-bit word
Push_Data  input  32  push word
Pop  input  1  pop request, one 16-bit halfword
Pop_Data  output  16  popped halfword, valid when Pop_Valid=1
Pop_Valid  output  1  one-cycle strobe, one cycle after an accepted pop
Full  output  1  count > 1022 (no room for 2 halfwords)
Empty  output  1  count == 0
Almost_Full  output  1  count >= AFULL_THRESH
Almost_Empty  output  1  count <= AEMPTY_THRESH
Count  output  11  occupancy in halfwords, 0..1024
Overflow  output  1  sticky: push attempted while Full
Underflow  output  1  sticky: pop attempted while Empty
Ram_WA  output  9  RAM write address
Ram_WD  output  32  RAM write data
Ram_WEN  output  4  RAM byte write enables
Ram_WClk_En  output  1  RAM write clock enable
Ram_RA  output  10  RAM read address
Ram_RClk_En  output  1  RAM read clock enable
Ram_RD  input  16  RAM read data (RAM read is unregistered: data appears the cycle after RA/RClk_En are sampled)

Behaviour:
- Reset (Rst_n=0, async): wptr=0, rptr=0, Count=0, Empty=1, Full=0, Almost_Empty=1, Almost_Full=0, Overflow=0, Underflow=0, Pop_Valid=0.
- push_ok = Push & ~Full. pop_ok = Pop & ~Empty. Both are evaluated on the pre-edge state.
- Write path (combinational): Ram_WA=wptr[8:0]; Ram_WD=Push_Data; Ram_WEN=4'hF if push_ok, else 4'h0; Ram_WClk_En=push_ok. On push_ok, wptr increments mod 512 at the edge.
- Read path (combinational): Ram_RA=rptr[9:0]; Ram_RClk_En=pop_ok. On pop_ok, rptr increments mod 1024.
- Halfword mapping: RA = {WA,0} returns WD[15:0]; RA = {WA,1} returns WD[31:16].
- Pop_Valid is a register: Pop_Valid <= pop_ok. Pop_Data = Ram_RD, passed through. Pop latency is 1 cycle, and back-to-back pops give back-to-back data.
- Count update per edge: +2 on push_ok, -1 on pop_ok, +1 on both. Count never exceeds 1024 and never goes negative. Empty, Full, Almost_* are derived combinationally from the registered Count.
- Simultaneous push and pop at Count=1023 is impossible, because Full is already set. At Count=1022 both are accepted, giving 1023.
- Read-after-write: a word pushed at edge N may be popped starting at edge N+1. Count becomes nonzero only after the write edge, so no same-cycle bypass is needed.
- Wrap-around: wptr 511->0 and rptr 1023->0 wrap silently. Occupancy comes from Count, not from pointer comparison.
- Errors: Push & Full sets Overflow; Pop & Empty sets Underflow. Both are sticky until Flush or reset. Rejected requests produce no RAM enable and no pointer or Count change.
- Flush (sync, priority over Push/Pop in the same cycle):
  - clears wptr, rptr, Count, Overflow, Underflow;
  - forces Ram_WEN=0, Ram_WClk_En=0, Ram_RClk_En=0 that cycle;
  - Pop_Valid <= 0.
- Reset mid-operation: all state returns to the reset values immediately. RAM contents are not cleared, and stale data is never surfaced because Count=0.

Test Plan:
- Reset, then push 0xBBBB_AAAA, then pop twice -> Pop_Data 0xAAAA then 0xBBBB, each with a Pop_Valid strobe 1 cycle after its pop; Count 2->1->0; Empty returns to 1.
- Push 512 words (i -> {16'h8000+i,16'hi}) -> Full=1 at Count=1024; a 513th push sets Overflow, Count stays 1024, Ram_WEN stays 0.
- Pop from empty -> Underflow=1, Pop_Valid stays 0, Ram_RClk_En=0, rptr unchanged.
- Steady stream of 1 push and 1 pop per cycle starting at Count=0 (first cycle push only) -> Count rises by 1 per cycle; the pop sequence matches low/high halves in order across the wptr 511->0 and rptr 1023->0 wraps.
- Count=1022 with simultaneous push and pop -> both accepted, Count=1023, Full=1. With AFULL_THRESH=960, Almost_Full asserts at 960, not at 958.
- Flush asserted together with Push and Pop at Count=10 -> next cycle Count=0, Empty=1, no RAM enables that cycle, Overflow and Underflow cleared. Async Rst_n pulse mid-stream -> outputs reach reset values without waiting for a Clk edge.
